// File: rtl/ntt_bitrev_reader.sv
// Bit-reversed read sweep over the NTT coefficient RAM, streamed out through a 2-entry skid FIFO.
// Optional build macro BITREV_READ_REVERSE_EN adds a 'down' input for a descending sweep.
module ntt_bitrev_reader #(
    parameter int N = 3,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
`ifdef BITREV_READ_REVERSE_EN
    input  logic         down,
`endif
    output logic         rd_en,
    output logic [N-1:0] rd_addr,
    input  logic [W-1:0] rd_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [N-1:0] out_idx,
    output logic         out_last,
    output logic         busy,
    output logic         done
);

    localparam int EW = W + N + 1;
    localparam logic [N-1:0] ONE = N'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t         state, state_nx;
    logic [N-1:0]   k;
    logic           dir;
    logic           load_dir;
    logic           k_final;
    logic           inflight;
    logic [N-1:0]   inflight_idx;
    logic           inflight_last;
    logic [EW-1:0]  fifo_mem [2];
    logic           wr_ptr, rd_ptr;
    logic [1:0]     count;
    logic [1:0]     occ;
    logic           push, pop;

`ifdef BITREV_READ_REVERSE_EN
    assign load_dir = down;
`else
    assign load_dir = 1'b0;
`endif

    assign k_final = dir ? (k == '0) : (k == '1);
    assign push    = inflight;
    assign pop     = out_valid && out_ready;
    assign occ     = count + {1'b0, inflight};

    // A word leaving this cycle frees its slot, so the next read may issue
    // now; without this the stream would only sustain one word every other cycle.
    assign rd_en = (state == ISSUE) && ((occ < 2'd2) || ((occ == 2'd2) && pop));

    always_comb begin
        rd_addr = '0;
        for (int i = 0; i < N; i++) begin
            rd_addr[i] = k[N-1-i];
        end
    end

    assign out_valid = (count != 2'd0);
    assign {out_data, out_idx, out_last} = fifo_mem[rd_ptr];
    assign busy = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = ISSUE;
            ISSUE:   if (rd_en && k_final) state_nx = DRAIN;
            DRAIN:   if (pop && out_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            k             <= '0;
            dir           <= 1'b0;
            inflight      <= 1'b0;
            inflight_idx  <= '0;
            inflight_last <= 1'b0;
            fifo_mem[0]   <= '0;
            fifo_mem[1]   <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            count         <= 2'd0;
            done          <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= (state == DRAIN) && pop && out_last;

            if (state == IDLE && start) begin
                k   <= load_dir ? '1 : '0;
                dir <= load_dir;
            end else if (rd_en) begin
                k <= dir ? (k - ONE) : (k + ONE);
            end

            // Sideband travels alongside the read so it lands with rd_data.
            inflight      <= rd_en;
            inflight_idx  <= k;
            inflight_last <= k_final;

            if (push) begin
                fifo_mem[wr_ptr] <= {rd_data, inflight_idx, inflight_last};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule
